// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone classic arbiter with round-robin grant locked per cyc burst.
// A bus watchdog turns a slave that never answers a strobe into a one-cycle err to the granted master.
module wb_arbiter2 #(
  parameter int ADDR_WIDTH = 20,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0__adr,
  input  logic [31:0]           m0__dat_w,
  input  logic [3:0]            m0__sel,
  input  logic                  m0__we,
  input  logic                  m0__cyc,
  input  logic                  m0__stb,
  output logic [31:0]           m0__dat_r,
  output logic                  m0__ack,
  output logic                  m0__err,
  input  logic [ADDR_WIDTH-1:0] m1__adr,
  input  logic [31:0]           m1__dat_w,
  input  logic [3:0]            m1__sel,
  input  logic                  m1__we,
  input  logic                  m1__cyc,
  input  logic                  m1__stb,
  output logic [31:0]           m1__dat_r,
  output logic                  m1__ack,
  output logic                  m1__err,
  output logic [ADDR_WIDTH-1:0] s__adr,
  output logic [31:0]           s__dat_w,
  output logic [3:0]            s__sel,
  output logic                  s__we,
  output logic                  s__cyc,
  output logic                  s__stb,
  input  logic [31:0]           s__dat_r,
  input  logic                  s__ack,
  input  logic                  s__err,
  output logic [1:0]            gnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  localparam logic [15:0] WD_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  logic [1:0]  state_q, state_d;
  logic        last_gnt_q, last_gnt_d;  // 1 = m1 held the bus last
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        wd_err_q, wd_err_d;
  logic        sel_m0, sel_m1;

  assign sel_m0 = (state_q == GNT0);
  assign sel_m1 = (state_q == GNT1);
  assign gnt    = {sel_m1, sel_m0};

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    s__adr   = '0;
    s__dat_w = '0;
    s__sel   = '0;
    s__we    = 1'b0;
    s__cyc   = 1'b0;
    s__stb   = 1'b0;
    if (sel_m0) begin
      s__adr   = m0__adr;
      s__dat_w = m0__dat_w;
      s__sel   = m0__sel;
      s__we    = m0__we;
      s__cyc   = m0__cyc;
      s__stb   = m0__stb & ~wd_err_q;
    end else if (sel_m1) begin
      s__adr   = m1__adr;
      s__dat_w = m1__dat_w;
      s__sel   = m1__sel;
      s__we    = m1__we;
      s__cyc   = m1__cyc;
      s__stb   = m1__stb & ~wd_err_q;
    end
  end

  assign m0__dat_r = s__dat_r;
  assign m1__dat_r = s__dat_r;
  // A late slave ack coinciding with the watchdog err is swallowed.
  assign m0__ack   = sel_m0 & s__ack & ~wd_err_q;
  assign m1__ack   = sel_m1 & s__ack & ~wd_err_q;
  assign m0__err   = sel_m0 & (s__err | wd_err_q);
  assign m1__err   = sel_m1 & (s__err | wd_err_q);

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (m0__cyc && m1__cyc) state_d = last_gnt_q ? GNT0 : GNT1;
        else if (m0__cyc)       state_d = GNT0;
        else if (m1__cyc)       state_d = GNT1;
      end
      GNT0: if (!m0__cyc) begin
        state_d    = IDLE;
        last_gnt_d = 1'b0;
      end
      GNT1: if (!m1__cyc) begin
        state_d    = IDLE;
        last_gnt_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wd_cnt_d = '0;
    wd_err_d = 1'b0;
    if (TIMEOUT != 0 && state_q != IDLE && s__stb && !(s__ack || s__err)) begin
      if (wd_cnt_q == WD_LAST) wd_err_d = 1'b1;
      else                     wd_cnt_d = wd_cnt_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      wd_cnt_q   <= '0;
      wd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      wd_cnt_q   <= wd_cnt_d;
      wd_err_q   <= wd_err_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed scenarios plus randomized traffic against a
// transaction-level model of ownership, fairness and unanswered-strobe timeouts.
module tb_wb_arbiter2;
  localparam int AW = 20;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] m0__adr, m1__adr;
  logic [31:0]   m0__dat_w, m1__dat_w;
  logic [3:0]    m0__sel, m1__sel;
  logic          m0__we, m0__cyc, m0__stb, m1__we, m1__cyc, m1__stb;
  logic [31:0]   s__dat_r;
  logic          s__ack, s__err;

  logic [31:0]   m0__dat_r, m1__dat_r;
  logic          m0__ack, m0__err, m1__ack, m1__err;
  logic [AW-1:0] s__adr;
  logic [31:0]   s__dat_w;
  logic [3:0]    s__sel;
  logic          s__we, s__cyc, s__stb;
  logic [1:0]    gnt;

  logic [31:0]   nw_m0__dat_r, nw_m1__dat_r;
  logic          nw_m0__ack, nw_m0__err, nw_m1__ack, nw_m1__err;
  logic [AW-1:0] nw_s__adr;
  logic [31:0]   nw_s__dat_w;
  logic [3:0]    nw_s__sel;
  logic          nw_s__we, nw_s__cyc, nw_s__stb;
  logic [1:0]    nw_gnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the bus, who owned it last, how long the current strobe waited.
  int m_owner = -1;
  int m_last  = 1;
  int m_wait  = 0;
  bit m_wd    = 1'b0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0__adr(m0__adr), .m0__dat_w(m0__dat_w), .m0__sel(m0__sel), .m0__we(m0__we),
    .m0__cyc(m0__cyc), .m0__stb(m0__stb), .m0__dat_r(m0__dat_r), .m0__ack(m0__ack), .m0__err(m0__err),
    .m1__adr(m1__adr), .m1__dat_w(m1__dat_w), .m1__sel(m1__sel), .m1__we(m1__we),
    .m1__cyc(m1__cyc), .m1__stb(m1__stb), .m1__dat_r(m1__dat_r), .m1__ack(m1__ack), .m1__err(m1__err),
    .s__adr(s__adr), .s__dat_w(s__dat_w), .s__sel(s__sel), .s__we(s__we), .s__cyc(s__cyc),
    .s__stb(s__stb), .s__dat_r(s__dat_r), .s__ack(s__ack), .s__err(s__err), .gnt(gnt)
  );

  wb_arbiter2 #(.ADDR_WIDTH(AW), .TIMEOUT(0)) dut_nowd (
    .clk(clk), .rst(rst),
    .m0__adr(m0__adr), .m0__dat_w(m0__dat_w), .m0__sel(m0__sel), .m0__we(m0__we),
    .m0__cyc(m0__cyc), .m0__stb(m0__stb), .m0__dat_r(nw_m0__dat_r), .m0__ack(nw_m0__ack), .m0__err(nw_m0__err),
    .m1__adr(m1__adr), .m1__dat_w(m1__dat_w), .m1__sel(m1__sel), .m1__we(m1__we),
    .m1__cyc(m1__cyc), .m1__stb(m1__stb), .m1__dat_r(nw_m1__dat_r), .m1__ack(nw_m1__ack), .m1__err(nw_m1__err),
    .s__adr(nw_s__adr), .s__dat_w(nw_s__dat_w), .s__sel(nw_s__sel), .s__we(nw_s__we), .s__cyc(nw_s__cyc),
    .s__stb(nw_s__stb), .s__dat_r(s__dat_r), .s__ack(s__ack), .s__err(s__err), .gnt(nw_gnt)
  );

  task automatic model_step();
    bit [1:0] cyc_v;
    bit strobing;
    cyc_v = {m1__cyc, m0__cyc};
    if (rst) begin
      m_owner = -1; m_last = 1; m_wait = 0; m_wd = 1'b0;
      return;
    end
    strobing = (m_owner == 0 && m0__stb && !m_wd) || (m_owner == 1 && m1__stb && !m_wd);
    if (TO > 0 && strobing && !(s__ack || s__err)) begin
      m_wait++;
      m_wd = (m_wait == TO);
      if (m_wd) m_wait = 0;
    end else begin
      m_wait = 0;
      m_wd   = 1'b0;
    end
    if (m_owner < 0) begin
      if (cyc_v == 2'b11) m_owner = 1 - m_last;
      else if (cyc_v[0])  m_owner = 0;
      else if (cyc_v[1])  m_owner = 1;
    end else if (!cyc_v[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    m0__adr = '0; m0__dat_w = '0; m0__sel = '0; m0__we = 1'b0; m0__cyc = 1'b0; m0__stb = 1'b0;
    m1__adr = '0; m1__dat_w = '0; m1__sel = '0; m1__we = 1'b0; m1__cyc = 1'b0; m1__stb = 1'b0;
    s__dat_r = '0; s__ack = 1'b0; s__err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    m0__adr = 20'h00005; m0__dat_w = 32'h1234_5678; m0__sel = 4'hF; m0__we = 1'b1;
    tick(); tick();
    @(negedge clk);
    n_checks++; if (gnt !== 2'b00) $display("FAIL rst_gnt: got %b want 00", gnt); else n_pass++;
    n_checks++; if ({s__cyc, s__stb, s__we} !== 3'b000) $display("FAIL rst_ctl: got %b want 000", {s__cyc, s__stb, s__we}); else n_pass++;
    n_checks++; if (s__adr !== '0 || s__dat_w !== '0 || s__sel !== '0) $display("FAIL rst_bus: got adr=%h dat=%h sel=%h want 0", s__adr, s__dat_w, s__sel); else n_pass++;
    n_checks++; if ({m0__ack, m0__err, m1__ack, m1__err} !== 4'b0000) $display("FAIL rst_resp: got %b want 0000", {m0__ack, m0__err, m1__ack, m1__err}); else n_pass++;
    clear_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_m0_read();
    m0__adr = 20'h00010; m0__sel = 4'hF; m0__cyc = 1'b1; m0__stb = 1'b1;
    @(negedge clk);
    n_checks++; if (gnt !== 2'b00) $display("FAIL rd_latency: got %b want 00", gnt); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (gnt !== 2'b01) $display("FAIL rd_gnt: got %b want 01", gnt); else n_pass++;
    n_checks++; if (s__adr !== 20'h00010 || s__stb !== 1'b1) $display("FAIL rd_fwd: got adr=%h stb=%b want 00010/1", s__adr, s__stb); else n_pass++;
    n_checks++; if (m0__ack !== 1'b0) $display("FAIL rd_early_ack: got %b want 0", m0__ack); else n_pass++;
    tick();
    s__ack = 1'b1; s__dat_r = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++; if (m0__ack !== 1'b1 || m0__dat_r !== 32'hDEAD_BEEF) $display("FAIL rd_ack: got ack=%b dat=%h want 1/deadbeef", m0__ack, m0__dat_r); else n_pass++;
    n_checks++; if (m1__ack !== 1'b0) $display("FAIL rd_m1_ack: got %b want 0", m1__ack); else n_pass++;
    tick();
    clear_inputs();
    @(negedge clk);
    n_checks++; if (gnt !== 2'b01 || s__cyc !== 1'b0) $display("FAIL rd_drop: got gnt=%b cyc=%b want 01/0", gnt, s__cyc); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (gnt !== 2'b00) $display("FAIL rd_release: got %b want 00", gnt); else n_pass++;
  endtask

  task automatic test_round_robin();
    clear_inputs();
    do_reset();
    m0__cyc = 1'b1; m0__stb = 1'b1; m1__cyc = 1'b1; m1__stb = 1'b1;
    tick();
    @(negedge clk);
    n_checks++; if (gnt !== 2'b01) $display("FAIL rr_first: got %b want 01", gnt); else n_pass++;
    m0__cyc = 1'b0; m0__stb = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if (gnt !== 2'b00) $display("FAIL rr_dead: got %b want 00", gnt); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (gnt !== 2'b10) $display("FAIL rr_second: got %b want 10", gnt); else n_pass++;
    m1__cyc = 1'b0; m1__stb = 1'b0;
    tick();
    m0__cyc = 1'b1; m0__stb = 1'b1; m1__cyc = 1'b1; m1__stb = 1'b1;
    @(negedge clk);
    n_checks++; if (gnt !== 2'b00) $display("FAIL rr_idle: got %b want 00", gnt); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (gnt !== 2'b01) $display("FAIL rr_alternate: got %b want 01", gnt); else n_pass++;
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_burst_lock();
    m1__cyc = 1'b1; m1__we = 1'b1; m1__sel = 4'b0011;
    tick();
    m0__cyc = 1'b1; m0__stb = 1'b1; m0__adr = 20'h0BEEF;
    for (int k = 1; k <= 4; k++) begin
      m1__stb = 1'b1; m1__dat_w = 32'(k); m1__adr = 20'(20'h00100 + k);
      s__ack = 1'b1;
      @(negedge clk);
      n_checks++; if (gnt !== 2'b10) $display("FAIL burst_gnt%0d: got %b want 10", k, gnt); else n_pass++;
      n_checks++; if (s__dat_w !== 32'(k) || s__sel !== 4'b0011 || s__we !== 1'b1 || s__adr !== 20'(20'h00100 + k))
        $display("FAIL burst_wr%0d: got dat=%h sel=%b we=%b adr=%h", k, s__dat_w, s__sel, s__we, s__adr); else n_pass++;
      n_checks++; if (m1__ack !== 1'b1 || m0__ack !== 1'b0) $display("FAIL burst_ack%0d: got m1=%b m0=%b want 1/0", k, m1__ack, m0__ack); else n_pass++;
      tick();
      m1__stb = 1'b0; s__ack = 1'b0;
      @(negedge clk);
      n_checks++; if (gnt !== 2'b10 || s__stb !== 1'b0) $display("FAIL burst_gap%0d: got gnt=%b stb=%b want 10/0", k, gnt, s__stb); else n_pass++;
      tick();
    end
    m1__cyc = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if (gnt !== 2'b00) $display("FAIL burst_dead: got %b want 00", gnt); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (gnt !== 2'b01 || s__adr !== 20'h0BEEF) $display("FAIL burst_m0: got gnt=%b adr=%h want 01/0beef", gnt, s__adr); else n_pass++;
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_watchdog();
    m0__cyc = 1'b1; m0__stb = 1'b1; m0__adr = 20'h00400;
    tick();
    for (int c = 0; c < 18; c++) begin
      if (c == 17) s__ack = 1'b1;
      @(negedge clk);
      if (c == 8 || c == 17) begin
        n_checks++; if (m0__err !== 1'b1 || s__stb !== 1'b0) $display("FAIL wd_fire%0d: got err=%b stb=%b want 1/0", c, m0__err, s__stb); else n_pass++;
      end else begin
        n_checks++; if (m0__err !== 1'b0 || s__stb !== 1'b1) $display("FAIL wd_wait%0d: got err=%b stb=%b want 0/1", c, m0__err, s__stb); else n_pass++;
      end
      if (c == 17) begin
        n_checks++; if (m0__ack !== 1'b0) $display("FAIL wd_late_ack: got %b want 0", m0__ack); else n_pass++;
      end
      n_checks++; if (m1__err !== 1'b0) $display("FAIL wd_m1_err%0d: got %b want 0", c, m1__err); else n_pass++;
      tick();
    end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_no_timeout();
    m0__cyc = 1'b1; m0__stb = 1'b1;
    tick();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      n_checks++; if (nw_m0__err !== 1'b0 || nw_gnt !== 2'b01 || nw_s__stb !== 1'b1)
        $display("FAIL nowd_c%0d: got err=%b gnt=%b stb=%b want 0/01/1", c, nw_m0__err, nw_gnt, nw_s__stb); else n_pass++;
      tick();
    end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    m1__cyc = 1'b1; m1__stb = 1'b1; m1__adr = 20'h00777;
    tick();
    @(negedge clk);
    n_checks++; if (gnt !== 2'b10 || s__stb !== 1'b1) $display("FAIL rmid_pre: got gnt=%b stb=%b want 10/1", gnt, s__stb); else n_pass++;
    rst = 1'b1;
    tick();
    s__ack = 1'b1;
    @(negedge clk);
    n_checks++; if (gnt !== 2'b00 || s__cyc !== 1'b0) $display("FAIL rmid_idle: got gnt=%b cyc=%b want 00/0", gnt, s__cyc); else n_pass++;
    n_checks++; if (m1__ack !== 1'b0 || m1__err !== 1'b0) $display("FAIL rmid_resp: got ack=%b err=%b want 0/0", m1__ack, m1__err); else n_pass++;
    rst = 1'b0; s__ack = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if (gnt !== 2'b10 || s__adr !== 20'h00777) $display("FAIL rmid_regrant: got gnt=%b adr=%h want 10/00777", gnt, s__adr); else n_pass++;
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_random();
    logic [1:0] e_gnt;
    logic e_cyc, e_stb, e_a0, e_e0, e_a1, e_e1;
    logic [AW-1:0] e_adr;
    logic [31:0] e_dat;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (m0__cyc) m0__cyc = ($urandom_range(0, 5) != 0); else m0__cyc = ($urandom_range(0, 2) == 0);
      if (m1__cyc) m1__cyc = ($urandom_range(0, 5) != 0); else m1__cyc = ($urandom_range(0, 2) == 0);
      m0__stb = m0__cyc & 1'($urandom_range(0, 1));
      m1__stb = m1__cyc & 1'($urandom_range(0, 1));
      m0__adr = AW'($urandom); m1__adr = AW'($urandom);
      m0__dat_w = $urandom; m1__dat_w = $urandom;
      m0__sel = 4'($urandom); m1__sel = 4'($urandom);
      m0__we = 1'($urandom); m1__we = 1'($urandom);
      s__dat_r = $urandom;
      e_gnt = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
      e_cyc = (m_owner == 0) ? m0__cyc : (m_owner == 1) ? m1__cyc : 1'b0;
      e_stb = !m_wd && ((m_owner == 0) ? m0__stb : (m_owner == 1) ? m1__stb : 1'b0);
      e_adr = (m_owner == 0) ? m0__adr : (m_owner == 1) ? m1__adr : '0;
      e_dat = (m_owner == 0) ? m0__dat_w : (m_owner == 1) ? m1__dat_w : '0;
      s__ack = e_stb && ($urandom_range(0, 3) == 0);
      s__err = e_stb && !s__ack && ($urandom_range(0, 19) == 0);
      e_a0 = (m_owner == 0) && s__ack && !m_wd;
      e_a1 = (m_owner == 1) && s__ack && !m_wd;
      e_e0 = (m_owner == 0) && (s__err || m_wd);
      e_e1 = (m_owner == 1) && (s__err || m_wd);
      @(negedge clk);
      n_checks++; if (gnt !== e_gnt) $display("FAIL rnd_gnt%0d: got %b want %b", n, gnt, e_gnt); else n_pass++;
      n_checks++; if (s__cyc !== e_cyc || s__stb !== e_stb) $display("FAIL rnd_ctl%0d: got cyc=%b stb=%b want %b/%b", n, s__cyc, s__stb, e_cyc, e_stb); else n_pass++;
      n_checks++; if (s__adr !== e_adr || s__dat_w !== e_dat) $display("FAIL rnd_bus%0d: got %h/%h want %h/%h", n, s__adr, s__dat_w, e_adr, e_dat); else n_pass++;
      n_checks++; if ({m0__ack, m0__err, m1__ack, m1__err} !== {e_a0, e_e0, e_a1, e_e1})
        $display("FAIL rnd_resp%0d: got %b want %b", n, {m0__ack, m0__err, m1__ack, m1__err}, {e_a0, e_e0, e_a1, e_e1}); else n_pass++;
      n_checks++; if (m0__dat_r !== s__dat_r || m1__dat_r !== s__dat_r) $display("FAIL rnd_datr%0d: got %h/%h want %h", n, m0__dat_r, m1__dat_r, s__dat_r); else n_pass++;
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    tick(); tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_m0_read();
    test_round_robin();
    test_burst_lock();
    test_watchdog();
    test_no_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
Two-master to one-slave Wishbone classic arbiter that shares the main memory port (the RAM slave at BASE_ADDR) between the core's mport and a second master (debug/DMA).
- Grant is round-robin and locked for the whole cyc burst.
- A built-in bus watchdog converts a hung slave cycle into an err response to the granted master.
- Sits between altair_core/second master and the ram instance in the top level.

Parameters:
ADDR_WIDTH, 20, address width of all adr ports
TIMEOUT, 255, cycles of stb without ack/err before watchdog err; 0 disables watchdog (max 65535)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
m0__adr  input  ADDR_WIDTH  master 0 address
m0__dat_w  input  32  master 0 write data
m0__sel  input  4  master 0 byte select
m0__we  input  1  master 0 write enable
m0__cyc  input  1  master 0 cycle
m0__stb  input  1  master 0 strobe
m0__dat_r  output  32  master 0 read data
m0__ack  output  1  master 0 ack
m0__err  output  1  master 0 error
m1__adr, m1__dat_w, m1__sel, m1__we, m1__cyc, m1__stb, m1__dat_r, m1__ack, m1__err: same as m0 for master 1
s__adr  output  ADDR_WIDTH  slave address
s__dat_w  output  32  slave write data
s__sel  output  4  slave byte select
s__we  output  1  slave write enable
s__cyc  output  1  slave cycle
s__stb  output  1  slave strobe
s__dat_r  input  32  slave read data
s__ack  input  1  slave ack
s__err  input  1  slave error
gnt  output  2  one-hot current grant (bit0=m0, bit1=m1), 00 when idle

Behaviour:
- Single clock clk; reset is synchronous, active-high (rst). All state updates on rising clk edge only.
- FSM states: IDLE, GNT0, GNT1; registered state, gnt = {state==GNT1, state==GNT0}.
- Reset: state IDLE, last_gnt=1 (m0 wins first tie), watchdog counter 0, timeout flag 0. Outputs: gnt=00, s__cyc/s__stb/s__we=0, s__adr/s__dat_w/s__sel=0, m*__ack/m*__err=0.
- IDLE: only m0__cyc -> GNT0; only m1__cyc -> GNT1; both -> master other than last_gnt; none -> stay. Decision registered: slave sees granted master one cycle after cyc first seen (1-cycle arbitration latency).
- GNTx: s__adr/dat_w/sel/we/cyc/stb combinationally = mx signals. mx__ack = s__ack, mx__err = s__err | wd_err. Other master: ack=0, err=0.
- s__cyc/s__stb/s__we forced 0 and adr/dat_w/sel 0 in IDLE.
- m0__dat_r = m1__dat_r = s__dat_r (broadcast, ignored without ack).
- Leave GNTx when mx__cyc==0 (sampled): -> IDLE, last_gnt=x. Stb may toggle while cyc held; grant stays (burst lock). One dead IDLE cycle between grants, no back-to-back handover.
- Granted master deasserting cyc while stb pending: slave cyc drops the same cycle (combinational), FSM -> IDLE next edge.
- Watchdog (TIMEOUT>0): 16-bit counter cleared when not in GNTx, when s__stb==0, or when s__ack|s__err. Otherwise increments. When counter == TIMEOUT-1 and no ack/err this cycle: wd_err registered, asserted to granted master for exactly one cycle next cycle; counter clears. While wd_err is high, s__stb forced 0 so the slave sees the strobe aborted. A late slave ack arriving on the wd_err cycle is suppressed (ack masked) for that cycle.
- TIMEOUT=0: counter held 0, wd_err never asserts.
- Reset mid-transfer: next edge IDLE, all outputs to reset values; in-flight slave cycle is abandoned.
- Masters must not assert stb without cyc; behaviour then undefined.

Test Plan:
- Reset, m0 reads adr 0x00010, slave acks after 2 cycles with 0xDEADBEEF -> gnt=01 one cycle after m0__cyc, m0__ack 1 cycle with m0__dat_r=0xDEADBEEF, m1__ack stays 0, gnt=00 after cyc drop.
- m0 and m1 raise cyc on the same cycle after reset -> m0 granted first (gnt=01). After m0 drops cyc, one IDLE cycle, then gnt=10. Repeat simultaneous request -> m0 next (alternation).
- m1 holds cyc for 4 single-beat writes (sel=4'b0011, dat 0x1..0x4) while m0 requests -> all 4 writes reach slave with gnt=10 throughout. m0 is granted only after m1 drops cyc.
- TIMEOUT=8, slave never acks m0 stb -> m0__err=1 exactly one cycle 8 cycles after stb seen by slave, s__stb=0 that cycle. Counter restarts if m0 keeps stb.
- TIMEOUT=0, slave silent 1000 cycles -> no err, grant held.
- Assert rst during m1 grant with stb pending -> next cycle gnt=00, s__cyc=0, m1__ack/err=0. Subsequent m1 request is granted normally.
